variable_latency_bank_ctrl: RTL and testbench
=============================================

Name: variable_latency_bank_ctrl

Overview:
- Target-side controller for one memory bank behind the variable-latency interconnect.
- Takes one target port of the interconnect (valid/ready request, valid/ready response tagged with initiator address) and sequences a fixed-latency SRAM macro.
- Tracks outstanding reads with a credit counter and buffers read data in a response FIFO, so interconnect response backpressure never loses SRAM data.

Parameters:
- NumIn, 32, initiators on the interconnect; tag width IniW = $clog2(NumIn).
- AddrMemWidth, 12, bank word-address width.
- DataWidth, 32, data word width.
- BeWidth, DataWidth/8, byte-enable width.
- MemLatency, 1, SRAM read latency in cycles; must be ≥1, elaboration $fatal otherwise.
- RespFifoDepth, MemLatency+1, response credits; must be ≥1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  request valid from interconnect.
- req_ready_o  out  1  request ready.
- req_ini_addr_i  in  IniW  requesting initiator.
- req_tgt_addr_i  in  AddrMemWidth  word address.
- req_wen_i  in  1  1 = write, 0 = read.
- req_wdata_i  in  DataWidth  write data.
- req_be_i  in  BeWidth  byte enables.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response ready.
- resp_ini_addr_o  out  IniW  initiator tag of response.
- resp_rdata_o  out  DataWidth  read data.
- mem_req_o  out  1  SRAM access strobe.
- mem_we_o  out  1  SRAM write enable.
- mem_addr_o  out  AddrMemWidth  SRAM address.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_be_o  out  BeWidth  SRAM byte enables.
- mem_rdata_i  in  DataWidth  SRAM read data, valid MemLatency cycles after a read strobe.

Behaviour:
- Credit counter `cnt` (0..RespFifoDepth) = reads in SRAM pipeline + FIFO entries.
- req_ready_o = (cnt < RespFifoDepth).
  - Registered-state only; no combinational path from resp_ready_i.
  - Applies to reads and writes alike.
- Accept = req_valid_i & req_ready_o.
  - mem_req_o = accept, combinational.
  - mem_we_o/addr/wdata/be driven directly from the request fields.
- Writes produce no response and do not change cnt.
- Read accept in cycle t:
  - Push {1, req_ini_addr_i} into a MemLatency-deep valid/tag shift pipeline.
  - cnt += 1.
- Pipeline exit (cycle t+MemLatency): push {tag, mem_rdata_i} into the FIFO in that cycle.
  - The FIFO cannot overflow, because of the credits.
- FIFO is fall-through.
  - With the FIFO empty, resp_valid_o rises in cycle t+MemLatency, combinationally from the pipeline exit.
  - Otherwise the head is driven.
- Response handshake (resp_valid_o & resp_ready_i): pop; cnt -= 1.
- Simultaneous read accept and response pop: cnt unchanged.
- Responses are strictly in acceptance order.
- resp_valid_o, once high, holds its data stable until the handshake.
- Throughput: back-to-back reads at 1/cycle sustained iff RespFifoDepth ≥ MemLatency+1 and resp_ready_i is held high.
- Full condition: cnt == RespFifoDepth → req_ready_o = 0, including for writes. Ready reasserts the cycle after the pop.
- Reset (also mid-operation), outputs and state:
  - cnt = 0, pipeline valids = 0, FIFO emptied.
  - req_ready_o = 1 on the first cycle after reset; resp_valid_o = 0; mem_req_o = 0.
  - In-flight SRAM data arriving after reset is discarded.
- During reset: req_ready_o = 0 and mem_req_o = 0.

Test Plan:
- Single read, MemLatency=1, Depth=2, resp_ready=1:
  - Stimulus: read addr 0x010, ini 5 in cycle 0; SRAM returns 0xDEADBEEF.
  - Expected: mem_req_o=1, we=0 in cycle 0; resp_valid_o=1 with ini 5, rdata 0xDEADBEEF in cycle 1; cnt back to 0 in cycle 2.
- Streaming:
  - Stimulus: 8 consecutive reads, ini 0..7, resp_ready=1.
  - Expected: req_ready_o stays 1; 8 responses on consecutive cycles 1..8 with tags 0..7 in order.
- Backpressure, MemLatency=2, Depth=3, resp_ready=0:
  - Stimulus: issue reads.
  - Expected: exactly 3 accepted, then req_ready_o=0 and remains 0 with a write pending.
  - Then raise resp_ready: 3 in-order responses; ready returns the cycle after the first pop.
- Write:
  - Stimulus: wen=1, be=4'b0101, wdata 0x12345678, addr 0xABC.
  - Expected: mem_we_o=1 with identical fields in the same cycle; no resp_valid_o ever; cnt stays 0.
- Simultaneous accept and pop at cnt=Depth−1: cnt unchanged, next request still accepted.
- Reset mid-operation:
  - Stimulus: assert rst_i with 2 reads in flight and 1 response queued.
  - Expected: next cycle resp_valid_o=0, req_ready_o=1; late mem_rdata_i produces no response.

Source files
------------

// File: rtl/variable_latency_bank_ctrl.sv
// rtl/variable_latency_bank_ctrl.sv - credit-based target controller for one fixed-latency SRAM bank
module variable_latency_bank_ctrl #(
    parameter int NumIn         = 32,
    parameter int AddrMemWidth  = 12,
    parameter int DataWidth     = 32,
    parameter int BeWidth       = DataWidth / 8,
    parameter int MemLatency    = 1,
    parameter int RespFifoDepth = MemLatency + 1,
    localparam int IniW         = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [IniW-1:0]         req_ini_addr_i,
    input  logic [AddrMemWidth-1:0] req_tgt_addr_i,
    input  logic                    req_wen_i,
    input  logic [DataWidth-1:0]    req_wdata_i,
    input  logic [BeWidth-1:0]      req_be_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [IniW-1:0]         resp_ini_addr_o,
    output logic [DataWidth-1:0]    resp_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [AddrMemWidth-1:0] mem_addr_o,
    output logic [DataWidth-1:0]    mem_wdata_o,
    output logic [BeWidth-1:0]      mem_be_o,
    input  logic [DataWidth-1:0]    mem_rdata_i
);

    localparam int CntW = $clog2(RespFifoDepth + 1);
    localparam int PtrW = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;

    if (MemLatency < 1) begin : g_bad_latency
        $fatal(1, "MemLatency must be at least 1");
    end
    if (RespFifoDepth < 1) begin : g_bad_depth
        $fatal(1, "RespFifoDepth must be at least 1");
    end

    // Credits: reads in the SRAM pipeline plus entries waiting in the FIFO.
    logic [CntW-1:0]      cnt;
    logic [CntW-1:0]      fifo_cnt;
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [MemLatency-1:0] pipe_vld;
    logic [IniW-1:0]      pipe_tag  [MemLatency];
    logic [IniW-1:0]      fifo_tag  [RespFifoDepth];
    logic [DataWidth-1:0] fifo_data [RespFifoDepth];

    logic            accept;
    logic            rd_accept;
    logic            exit_vld;
    logic [IniW-1:0] exit_tag;
    logic            fifo_empty;
    logic            resp_fire;
    logic            push;
    logic            pop;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(RespFifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Ready depends only on the credit register (and reset), never on resp_ready_i.
    assign req_ready_o = ~rst_i & (cnt < CntW'(RespFifoDepth));
    assign accept      = req_valid_i & req_ready_o;
    assign rd_accept   = accept & ~req_wen_i;

    assign mem_req_o   = accept;
    assign mem_we_o    = req_wen_i;
    assign mem_addr_o  = req_tgt_addr_i;
    assign mem_wdata_o = req_wdata_i;
    assign mem_be_o    = req_be_i;

    assign exit_vld   = pipe_vld[MemLatency-1];
    assign exit_tag   = pipe_tag[MemLatency-1];
    assign fifo_empty = (fifo_cnt == '0);

    // Fall-through: an empty FIFO presents the SRAM data the cycle it arrives.
    assign resp_valid_o    = fifo_empty ? exit_vld    : 1'b1;
    assign resp_ini_addr_o = fifo_empty ? exit_tag    : fifo_tag[rd_ptr];
    assign resp_rdata_o    = fifo_empty ? mem_rdata_i : fifo_data[rd_ptr];
    assign resp_fire       = resp_valid_o & resp_ready_i;

    // A bypassed response that is taken immediately never enters the FIFO.
    assign push = exit_vld & ~(fifo_empty & resp_ready_i);
    assign pop  = resp_fire & ~fifo_empty;

    // Shift read valid/tag alongside the SRAM latency; reset drops in-flight reads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_accept;
            for (int i = 1; i < MemLatency; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
        pipe_tag[0] <= req_ini_addr_i;
        for (int i = 1; i < MemLatency; i++) begin
            pipe_tag[i] <= pipe_tag[i-1];
        end
    end

    // Response FIFO storage and pointers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_tag[wr_ptr]  <= exit_tag;
                fifo_data[wr_ptr] <= mem_rdata_i;
                wr_ptr            <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CntW'(1);
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - CntW'(1);
            end
        end
    end

    // Credit counter: a read takes a credit, a response handshake returns it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (rd_accept && !resp_fire) begin
            cnt <= cnt + CntW'(1);
        end else if (resp_fire && !rd_accept) begin
            cnt <= cnt - CntW'(1);
        end
    end

endmodule

// File: tb/tb_variable_latency_bank_ctrl.sv
// tb/tb_variable_latency_bank_ctrl.sv - directed bench for variable_latency_bank_ctrl
module tb_variable_latency_bank_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [4:0]  req_ini;
    logic [11:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_ready;

    logic        a_req_ready, a_resp_valid, a_mem_req, a_mem_we;
    logic [4:0]  a_resp_ini;
    logic [31:0] a_resp_rdata, a_mem_wdata, a_rd;
    logic [11:0] a_mem_addr;
    logic [3:0]  a_mem_be;

    logic        b_req_ready, b_resp_valid, b_mem_req, b_mem_we;
    logic [4:0]  b_resp_ini;
    logic [31:0] b_resp_rdata, b_mem_wdata, b_rd1, b_rd2;
    logic [11:0] b_mem_addr;
    logic [3:0]  b_mem_be;

    int n_checks = 0;
    int n_fail   = 0;
    int accepted;

    variable_latency_bank_ctrl #(.MemLatency(1), .RespFifoDepth(2)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(a_req_ready),
        .req_ini_addr_i(req_ini), .req_tgt_addr_i(req_addr), .req_wen_i(req_wen),
        .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(a_resp_valid), .resp_ready_i(resp_ready),
        .resp_ini_addr_o(a_resp_ini), .resp_rdata_o(a_resp_rdata),
        .mem_req_o(a_mem_req), .mem_we_o(a_mem_we), .mem_addr_o(a_mem_addr),
        .mem_wdata_o(a_mem_wdata), .mem_be_o(a_mem_be), .mem_rdata_i(a_rd)
    );

    variable_latency_bank_ctrl #(.MemLatency(2), .RespFifoDepth(3)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(b_req_ready),
        .req_ini_addr_i(req_ini), .req_tgt_addr_i(req_addr), .req_wen_i(req_wen),
        .req_wdata_i(req_wdata), .req_be_i(req_be),
        .resp_valid_o(b_resp_valid), .resp_ready_i(resp_ready),
        .resp_ini_addr_o(b_resp_ini), .resp_rdata_o(b_resp_rdata),
        .mem_req_o(b_mem_req), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be), .mem_rdata_i(b_rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] sram_word(input logic [11:0] a);
        return (a == 12'h010) ? 32'hDEADBEEF : (32'hC000_0000 | {20'h0, a});
    endfunction

    // SRAM models: read data appears MemLatency cycles after the address.
    always @(posedge clk) begin
        a_rd  <= sram_word(a_mem_addr);
        b_rd1 <= sram_word(b_mem_addr);
        b_rd2 <= b_rd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req_valid = 1'b0;
        req_wen   = 1'b0;
    endtask

    task automatic set_read(input logic [4:0] ini, input logic [11:0] addr);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_ini   = ini;
        req_addr  = addr;
    endtask

    task automatic set_write(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] be);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = addr;
        req_wdata = d;
        req_be    = be;
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; req_ini = '0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b1;
        set_read(5'd1, 12'h001);
        tick(); tick();
        @(negedge clk);
        check_eq("rst_ready_a", a_req_ready, 0);
        check_eq("rst_memreq_a", a_mem_req, 0);
        check_eq("rst_ready_b", b_req_ready, 0);
        tick();
        rst = 1'b0; set_idle();
        @(negedge clk);
        check_eq("post_rst_ready_a", a_req_ready, 1);
        check_eq("post_rst_resp_a", a_resp_valid, 0);
        check_eq("post_rst_ready_b", b_req_ready, 1);
        check_eq("post_rst_cnt_a", dut_a.cnt, 0);
        tick();

        // Single read on the latency-1 bank.
        set_read(5'd5, 12'h010);
        @(negedge clk);
        check_eq("single_memreq", a_mem_req, 1);
        check_eq("single_we", a_mem_we, 0);
        check_eq("single_addr", a_mem_addr, 12'h010);
        tick(); set_idle();
        @(negedge clk);
        check_eq("single_rvalid", a_resp_valid, 1);
        check_eq("single_ini", a_resp_ini, 5);
        check_eq("single_rdata", a_resp_rdata, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        check_eq("single_cnt", dut_a.cnt, 0);
        check_eq("single_rvalid_lo", a_resp_valid, 0);
        idle_cycles(3);

        // Eight back-to-back reads stream one response per cycle.
        for (int c = 0; c <= 9; c++) begin
            if (c < 8) set_read(5'(c), 12'h100 + 12'(c)); else set_idle();
            @(negedge clk);
            if (c < 8) check_eq($sformatf("stream_ready%0d", c), a_req_ready, 1);
            if (c >= 1 && c <= 8) begin
                check_eq($sformatf("stream_valid%0d", c), a_resp_valid, 1);
                check_eq($sformatf("stream_ini%0d", c), a_resp_ini, c - 1);
                check_eq($sformatf("stream_data%0d", c), a_resp_rdata, 32'hC000_0100 + c - 1);
            end
            if (c == 9) check_eq("stream_end", a_resp_valid, 0);
            tick();
        end
        idle_cycles(3);

        // Backpressure on the latency-2, depth-3 bank.
        resp_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 6; c++) begin
            set_read(5'(10 + accepted), 12'h200 + 12'(accepted));
            @(negedge clk);
            if (b_req_ready) accepted++;
            if (c >= 3) check_eq($sformatf("bp_ready_lo%0d", c), b_req_ready, 0);
            tick();
        end
        check_eq("bp_accepts", accepted, 3);
        set_write(12'h3F0, 32'h55AA55AA, 4'hF);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_eq("bp_wr_ready", b_req_ready, 0);
            check_eq("bp_wr_memreq", b_mem_req, 0);
            check_eq("bp_hold_valid", b_resp_valid, 1);
            check_eq("bp_hold_ini", b_resp_ini, 10);
            check_eq("bp_hold_data", b_resp_rdata, 32'hC000_0200);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_r0_ini", b_resp_ini, 10);
        check_eq("bp_r0_ready", b_req_ready, 0);
        tick();
        @(negedge clk);
        check_eq("bp_r1_ready", b_req_ready, 1);
        check_eq("bp_r1_wr", b_mem_req & b_mem_we, 1);
        check_eq("bp_r1_ini", b_resp_ini, 11);
        check_eq("bp_r1_data", b_resp_rdata, 32'hC000_0201);
        tick(); set_idle();
        @(negedge clk);
        check_eq("bp_r2_ini", b_resp_ini, 12);
        check_eq("bp_r2_data", b_resp_rdata, 32'hC000_0202);
        tick();
        @(negedge clk);
        check_eq("bp_drained", b_resp_valid, 0);
        idle_cycles(3);

        // Write: pass-through fields, no response, no credit.
        set_write(12'hABC, 32'h12345678, 4'b0101);
        @(negedge clk);
        check_eq("wr_memreq", a_mem_req, 1);
        check_eq("wr_we", a_mem_we, 1);
        check_eq("wr_addr", a_mem_addr, 12'hABC);
        check_eq("wr_data", a_mem_wdata, 32'h12345678);
        check_eq("wr_be", a_mem_be, 4'b0101);
        tick(); set_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("wr_no_resp_a", a_resp_valid, 0);
            check_eq("wr_no_resp_b", b_resp_valid, 0);
            check_eq("wr_cnt", dut_a.cnt, 0);
            tick();
        end

        // Simultaneous accept and pop at cnt = Depth-1 on the depth-2 bank.
        resp_ready = 1'b0;
        set_read(5'd20, 12'h300);
        @(negedge clk);
        check_eq("sim_c0_ready", a_req_ready, 1);
        tick(); set_idle();
        @(negedge clk);
        check_eq("sim_c1_ini", a_resp_ini, 20);
        tick();
        resp_ready = 1'b1;
        set_read(5'd21, 12'h301);
        @(negedge clk);
        check_eq("sim_c2_cnt", dut_a.cnt, 1);
        check_eq("sim_c2_memreq", a_mem_req, 1);
        check_eq("sim_c2_ini", a_resp_ini, 20);
        tick();
        set_read(5'd22, 12'h302);
        @(negedge clk);
        check_eq("sim_c3_cnt", dut_a.cnt, 1);
        check_eq("sim_c3_memreq", a_mem_req, 1);
        check_eq("sim_c3_ini", a_resp_ini, 21);
        tick(); set_idle();
        @(negedge clk);
        check_eq("sim_c4_ini", a_resp_ini, 22);
        check_eq("sim_c4_data", a_resp_rdata, 32'hC000_0302);
        tick();
        @(negedge clk);
        check_eq("sim_c5_cnt", dut_a.cnt, 0);
        idle_cycles(3);

        // Reset with two reads in flight and one response queued.
        resp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_read(5'(1 + c), 12'h400 + 12'(c));
            tick();
        end
        rst = 1'b1;
        set_read(5'd9, 12'h4FF);
        @(negedge clk);
        check_eq("mrst_cnt_before", dut_b.cnt, 3);
        check_eq("mrst_ready", b_req_ready, 0);
        check_eq("mrst_memreq", b_mem_req, 0);
        tick();
        rst = 1'b0; set_idle(); resp_ready = 1'b1;
        @(negedge clk);
        check_eq("mrst_resp_lo", b_resp_valid, 0);
        check_eq("mrst_ready_hi", b_req_ready, 1);
        check_eq("mrst_cnt", dut_b.cnt, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("mrst_late_b", b_resp_valid, 0);
            check_eq("mrst_late_a", a_resp_valid, 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
